// File: rtl/aes_pipe_scheduler_if.sv
// Requester-side bus of the AES pipe scheduler: per-requester block handshake
// plus the shared ciphertext response channel.
interface aes_pipe_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 128
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic                     rsp_valid_o;
    logic [ID_W-1:0]          rsp_id_o;
    logic [WIDTH-1:0]         rsp_data_o;

    modport master (
        output req_valid_i, req_data_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_data_i,
        output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Round-robin scheduler sharing one pipelined AES-128 core among NUM_REQ
// requesters; owns the key and drains the pipe before any key change.
module aes_pipe_scheduler #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned PIPE_LAT = 10,
    parameter int unsigned KEY_LAT  = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 key_load_i,
    input  logic [WIDTH-1:0]     key_i,
    aes_pipe_scheduler_if.slave  req_if,
    output logic                 busy_o,
    output logic                 key_ready_o,
    output logic [WIDTH-1:0]     core_key_o,
    output logic                 core_key_valid_o,
    output logic [WIDTH-1:0]     core_plaintext_o,
    output logic                 core_data_valid_o,
    input  logic [WIDTH-1:0]     core_ciphertext_i
);
    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned INF_W = $clog2(PIPE_LAT + 3);
    localparam int unsigned KC_W  = $clog2(KEY_LAT + 1);

    localparam logic [1:0] ST_NOKEY   = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_KEYWAIT = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [KC_W-1:0]    kcnt_q, kcnt_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic [ID_W-1:0]    rr_q;
    logic [WIDTH-1:0]   pending_q;
    logic               load_key_c;

    logic [NUM_REQ-1:0] grant_c;
    logic               grant_vld_c;
    logic [ID_W-1:0]    grant_id_c;
    logic [ID_W-1:0]    cand_c;
    logic [WIDTH-1:0]   grant_data_c;

    logic [ID_W-1:0]    issue_id_q;
    logic [PIPE_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [PIPE_LAT];
    logic               rsp_fire_c;

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                               input int unsigned    off);
        int unsigned s;
        s = (32'(base) + off) % NUM_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin grant; a key load in the same cycle suppresses all grants.
    always_comb begin
        grant_c      = '0;
        grant_vld_c  = 1'b0;
        grant_id_c   = '0;
        cand_c       = '0;
        grant_data_c = '0;
        if (state_q == ST_RUN && !key_load_i) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand_c = rr_idx(rr_q, k);
                if (!grant_vld_c && req_if.req_valid_i[cand_c]) begin
                    grant_vld_c     = 1'b1;
                    grant_id_c      = cand_c;
                    grant_c[cand_c] = 1'b1;
                end
            end
        end
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (grant_c[r]) grant_data_c = req_if.req_data_i[r*WIDTH +: WIDTH];
        end
    end

    assign req_if.req_ready_o = grant_c;
    assign req_if.rsp_valid_o = rsp_valid_q;
    assign req_if.rsp_id_o    = rsp_id_q;
    assign req_if.rsp_data_o  = rsp_data_q;

    assign rsp_fire_c = tag_vld_q[PIPE_LAT-1];

    // Issue and response cancel out in the same cycle.
    always_comb begin
        inflight_d = inflight_q;
        if (grant_vld_c && !rsp_fire_c) begin
            inflight_d = inflight_q + INF_W'(1);
        end else if (!grant_vld_c && rsp_fire_c) begin
            inflight_d = inflight_q - INF_W'(1);
        end
    end

    // Key FSM: every entry into KEYWAIT (including re-entry) pulses the core key.
    always_comb begin
        state_d    = state_q;
        kcnt_d     = kcnt_q;
        load_key_c = 1'b0;
        case (state_q)
            ST_NOKEY: begin
                if (key_load_i) begin
                    state_d    = ST_KEYWAIT;
                    kcnt_d     = '0;
                    load_key_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (key_load_i) begin
                    if (inflight_q != '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d    = ST_KEYWAIT;
                        kcnt_d     = '0;
                        load_key_c = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d    = ST_KEYWAIT;
                    kcnt_d     = '0;
                    load_key_c = 1'b1;
                end
            end
            ST_KEYWAIT: begin
                if (key_load_i) begin
                    kcnt_d     = '0;
                    load_key_c = 1'b1;
                end else if (kcnt_q == KC_W'(KEY_LAT - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    kcnt_d = kcnt_q + KC_W'(1);
                end
            end
            default: begin
                state_d = ST_NOKEY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q           <= ST_NOKEY;
            kcnt_q            <= '0;
            inflight_q        <= '0;
            rr_q              <= '0;
            pending_q         <= '0;
            busy_o            <= 1'b1;
            key_ready_o       <= 1'b0;
            core_key_o        <= '0;
            core_key_valid_o  <= 1'b0;
            core_plaintext_o  <= '0;
            core_data_valid_o <= 1'b0;
            issue_id_q        <= '0;
            tag_vld_q         <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) tag_id_q[i] <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_id_q          <= '0;
            rsp_data_q        <= '0;
        end else begin
            state_q     <= state_d;
            kcnt_q      <= kcnt_d;
            inflight_q  <= inflight_d;
            busy_o      <= !(state_d == ST_RUN && inflight_d == '0);
            key_ready_o <= (state_d == ST_RUN);

            if (key_load_i) pending_q <= key_i;
            core_key_valid_o <= load_key_c;
            if (load_key_c) core_key_o <= key_load_i ? key_i : pending_q;

            core_data_valid_o <= grant_vld_c;
            if (grant_vld_c) begin
                core_plaintext_o <= grant_data_c;
                issue_id_q       <= grant_id_c;
                rr_q             <= rr_idx(grant_id_c, 1);
            end

            // Tag enters one cycle after issue so the tail lines up with the core output.
            tag_vld_q   <= {tag_vld_q[PIPE_LAT-2:0], core_data_valid_o};
            tag_id_q[0] <= issue_id_q;
            for (int unsigned i = 1; i < PIPE_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];

            rsp_valid_q <= rsp_fire_c;
            if (rsp_fire_c) begin
                rsp_id_q   <= tag_id_q[PIPE_LAT-1];
                rsp_data_q <= core_ciphertext_i;
            end
        end
    end
endmodule
